inv_mask_pipe: RTL and testbench
================================

INV_MASK_PIPE -- requirements
Module: inv_mask_pipe

Interface
REQ-001 Parameter N, default 8: data width in bits; legal range N >= 2.
REQ-002 Parameter DEFAULT_MASK, default N-bit value with every even-indexed bit set (0x55 at N=8): mask register reset value.
REQ-003 Parameter DEPTH, default 2: output buffer entries; legal range 2 to 16.
REQ-004 Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- n_reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  N  input word.
- mode  input  2  transform select, sampled on accept.
- mask_load  input  1  load mask_in into the mask register.
- mask_in  input  N  new mask value.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  N  transformed word at the buffer head.
- mask_q  output  N  current mask register value.
- word_count  output  16  count of accepted input words.

Function
REQ-005 Accept occurs in a cycle where in_valid and in_ready are both 1; pop occurs in a cycle where out_valid and out_ready are both 1.
REQ-006 Transform applied at accept, using the mask_q value before that edge:
- mode 00: pass-through, word = in_data.
- mode 01: static, word = in_data XOR mask_q.
- mode 10: rotating, word = in_data XOR mask_q.
- mode 11: full invert, word = NOT in_data.
REQ-007 In mode 10, each accept rotates mask_q left by one bit: bit N-1 moves to bit 0.
REQ-008 Rotation occurs only on an accept while mode is 10; mask_q does not rotate in any other mode, or when no word is accepted.
REQ-009 When mask_load is 1, mask_q becomes mask_in at the next edge, regardless of in_valid or in_ready.
REQ-010 mask_load has priority over rotation when both occur in the same cycle; that cycle's word still uses the old mask_q.
REQ-011 Transformed words enter a FIFO of DEPTH entries; pops occur in strict acceptance order.
REQ-012 Latency: a word accepted at edge k is presented on out_data with out_valid = 1 from the cycle after edge k, provided the FIFO was empty.
REQ-013 in_ready = 1 exactly when fewer than DEPTH entries are held; it is a function of registered occupancy only, with no combinational path from out_ready.
REQ-014 out_valid = 1 exactly when occupancy > 0; out_data = head entry; out_data is 0 when the FIFO is empty.
REQ-015 Accept and pop in the same cycle: occupancy is unchanged, and the pointers advance correctly.
REQ-016 When full, in_ready = 0, so no accept occurs; a pop at full returns occupancy to DEPTH-1 and in_ready to 1 on the following cycle.
REQ-017 out_data and out_valid hold stable while out_valid = 1 and out_ready = 0.
REQ-018 Read and write pointers wrap modulo DEPTH.
REQ-019 word_count increments by 1 on each accept and wraps from 0xFFFF to 0x0000.
REQ-020 A mode change takes effect on the next accept; words already buffered are unaffected.

Reset
REQ-021 While n_reset = 0, the block holds these values asynchronously:
- mask_q = DEFAULT_MASK;
- occupancy 0, pointers 0;
- word_count = 0;
- out_valid = 0, out_data = 0, in_ready = 0.
REQ-022 in_ready becomes 1 on the first rising edge after n_reset deasserts.
REQ-023 Reset asserted mid-transfer discards all buffered words; no partial word is presented afterwards.

Verification
REQ-024 N=8, mode 01, mask at reset, in_data 0xFF, out_ready=1 -> out_data 0xAA one cycle after accept, word_count=1.
REQ-025 Mode 10, mask 0x55, accept 0x00 three times -> outputs 0x55, 0xAA, 0x55, then mask_q=0xAA.
REQ-026 Same cycle: mask_load with mask_in 0x0F, plus an accept of 0x00 in mode 10 -> that output is 0x00 XOR the old mask, and mask_q=0x0F with no rotation.
REQ-027 DEPTH=2, out_ready=0, push 0x01, 0x02, 0x03 -> only two accepted and in_ready=0; then out_ready=1 -> 0x01 then 0x02 in order, and 0x03 is accepted after space frees.
REQ-028 Mode 11 with in_data 0x3C -> output 0xC3; 65536 accepts in total -> word_count wraps to 0x0000.
REQ-029 n_reset pulsed low with 2 words buffered and mask_q=0x0F -> out_valid=0 immediately, mask_q=0x55, word_count=0, no stale word after release.

Source files
------------

// File: rtl/inv_mask_pipe.sv
// inv_mask_pipe: per-word invert/mask transform feeding a small output FIFO.
// A mask register supplies the XOR pattern, optionally rotating on each
// accepted word, and a 16-bit counter tracks how many words were accepted.
module inv_mask_pipe #(
  parameter int unsigned   N            = 8,
  parameter logic [N-1:0]  DEFAULT_MASK = N'({((N + 1) / 2){2'b01}}),
  parameter int unsigned   DEPTH        = 2
) (
  input  logic          clk,
  input  logic          n_reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic [1:0]    mode,
  input  logic          mask_load,
  input  logic [N-1:0]  mask_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic [N-1:0]  mask_q,
  output logic [15:0]   word_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned WC_W  = 16;

  localparam logic [1:0] MODE_PASS   = 2'b00;
  localparam logic [1:0] MODE_STATIC = 2'b01;
  localparam logic [1:0] MODE_ROT    = 2'b10;
  localparam logic [1:0] MODE_INV    = 2'b11;

  logic [N-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [N-1:0]     mask_reg_q, mask_reg_d;
  logic [WC_W-1:0]  wcnt_q, wcnt_d;
  logic             rdy_en_q;

  logic             accept;
  logic             pop;
  logic [N-1:0]     word;

  // Handshakes; in_ready depends only on registered state.
  assign in_ready  = rdy_en_q && (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign mask_q     = mask_reg_q;
  assign word_count = wcnt_q;

  // Word transform using the mask value held before this edge.
  always_comb begin
    word = in_data;
    unique case (mode)
      MODE_PASS:   word = in_data;
      MODE_STATIC: word = in_data ^ mask_reg_q;
      MODE_ROT:    word = in_data ^ mask_reg_q;
      MODE_INV:    word = ~in_data;
      default:     word = in_data;
    endcase
  end

  // Next-state for mask, pointers, occupancy and accept counter.
  always_comb begin
    mask_reg_d = mask_reg_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    wcnt_d     = wcnt_q;

    // An explicit load wins over rotation; the current word already used the old mask.
    if (mask_load) begin
      mask_reg_d = mask_in;
    end else if (accept && (mode == MODE_ROT)) begin
      mask_reg_d = {mask_reg_q[N-2:0], mask_reg_q[N-1]};
    end

    if (accept) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      wcnt_d   = wcnt_q + WC_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end

    unique case ({accept, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state with asynchronous reset; rdy_en_q holds in_ready low until the first edge.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      mask_reg_q <= DEFAULT_MASK;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wcnt_q     <= '0;
      rdy_en_q   <= 1'b0;
    end else begin
      mask_reg_q <= mask_reg_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wcnt_q     <= wcnt_d;
      rdy_en_q   <= 1'b1;
    end
  end

  // FIFO storage; contents are don't-care while the occupancy marks them empty.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= word;
    end
  end

endmodule

// File: tb/tb_inv_mask_pipe.sv
// Scoreboard bench for inv_mask_pipe (N=8, DEPTH=2).
module tb_inv_mask_pipe;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [1:0]  mode;
  logic        mask_load;
  logic [7:0]  mask_in;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [7:0]  mask_q;
  logic [15:0] word_count;

  int n_tests = 0;
  int n_fail  = 0;
  int n_acc   = 0;
  logic [7:0] exp_q [$];

  inv_mask_pipe #(.N(8), .DEPTH(2)) dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .mode       (mode),
    .mask_load  (mask_load),
    .mask_in    (mask_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .mask_q     (mask_q),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every popped word against the scoreboard head.
  always @(negedge clk) begin
    if (n_reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_out: got 0x%0h expected no word", out_data);
      end else begin
        chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // Issue one word; called just after a rising edge.
  task automatic send(input logic [7:0] d, input logic [1:0] m, input logic [7:0] e,
                      input logic ld = 1'b0, input logic [7:0] lv = 8'h00);
    int t = 0;
    in_data   = d;
    mode      = m;
    in_valid  = 1'b1;
    mask_load = ld;
    mask_in   = lv;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready 0 expected 1 for data 0x%0h", d);
    end else begin
      exp_q.push_back(e);
      n_acc++;
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    mask_load = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    n_reset   = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    mode      = 2'b00;
    mask_load = 1'b0;
    mask_in   = 8'h00;
    out_ready = 1'b0;

    // Reset values
    #12;
    chk("rst_in_ready",   32'(in_ready),   32'd0);
    chk("rst_out_valid",  32'(out_valid),  32'd0);
    chk("rst_out_data",   32'(out_data),   32'd0);
    chk("rst_mask",       32'(mask_q),     32'h55);
    chk("rst_word_count", 32'(word_count), 32'd0);
    @(negedge clk);
    n_reset = 1'b1;
    #1;
    chk("rel_in_ready_pre", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // Static mask with reset mask, latency one cycle
    out_ready = 1'b1;
    send(8'hFF, 2'b01, 8'hAA);
    chk("lat_out_valid", 32'(out_valid),  32'd1);
    chk("lat_out_data",  32'(out_data),   32'hAA);
    chk("wc_one",        32'(word_count), 32'd1);
    drain();
    chk("mask_no_rot_static", 32'(mask_q), 32'h55);

    // Rotating mask
    send(8'h00, 2'b10, 8'h55);
    send(8'h00, 2'b10, 8'hAA);
    send(8'h00, 2'b10, 8'h55);
    drain();
    chk("rot_mask", 32'(mask_q), 32'hAA);

    // Load and rotate in the same cycle: load wins, word uses old mask
    send(8'h00, 2'b10, 8'hAA, 1'b1, 8'h0F);
    drain();
    chk("load_prio_mask", 32'(mask_q), 32'h0F);

    // Pass-through, invert, static with new mask, mode change between words
    send(8'h5A, 2'b00, 8'h5A);
    send(8'h3C, 2'b11, 8'hC3);
    send(8'hF0, 2'b01, 8'hFF);
    send(8'h0F, 2'b01, 8'h00);
    send(8'h12, 2'b01, 8'h1D);
    send(8'h12, 2'b00, 8'h12);
    drain();
    chk("mask_after_mix", 32'(mask_q), 32'h0F);

    // Mode 10 without an accept does not rotate
    mode = 2'b10;
    @(posedge clk);
    #1;
    chk("idle_no_rot", 32'(mask_q), 32'h0F);

    // Load without any transfer
    mask_load = 1'b1;
    mask_in   = 8'h3C;
    @(posedge clk);
    #1;
    mask_load = 1'b0;
    chk("load_idle", 32'(mask_q), 32'h3C);

    // Full FIFO backpressure and ordering
    out_ready = 1'b0;
    send(8'h01, 2'b00, 8'h01);
    send(8'h02, 2'b00, 8'h02);
    chk("full_in_ready", 32'(in_ready),  32'd0);
    chk("full_head",     32'(out_data),  32'h01);
    @(posedge clk);
    #1;
    chk("hold_valid", 32'(out_valid), 32'd1);
    chk("hold_data",  32'(out_data),  32'h01);
    fork
      begin
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
      send(8'h03, 2'b00, 8'h03);
    join
    drain();
    chk("wc_before_wrap", 32'(word_count), 32'(n_acc));

    // Counter wrap at 65536 accepts
    while (n_acc < 65536) begin
      send(8'h3C, 2'b11, 8'hC3);
    end
    drain();
    chk("wc_wrap", 32'(word_count), 32'd0);

    // Reset mid-transfer with words buffered
    out_ready = 1'b0;
    send(8'h11, 2'b00, 8'h11, 1'b1, 8'h0F);
    send(8'h22, 2'b00, 8'h22);
    chk("pre_rst_mask",  32'(mask_q),    32'h0F);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2;
    n_reset = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_valid", 32'(out_valid),  32'd0);
    chk("mid_rst_data",  32'(out_data),   32'd0);
    chk("mid_rst_mask",  32'(mask_q),     32'h55);
    chk("mid_rst_wc",    32'(word_count), 32'd0);
    chk("mid_rst_ready", 32'(in_ready),   32'd0);
    @(negedge clk);
    n_reset   = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("post_rst_no_stale", 32'(out_valid), 32'd0);
    end
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    send(8'h00, 2'b01, 8'h55);
    drain();
    chk("post_rst_wc", 32'(word_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
